// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator controller and its ALU:
// ALU opcodes, command codes and the controller FSM encoding.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OPT_W  = 3;
    localparam int unsigned CMD_W  = 4;

    typedef enum logic [OPT_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_NOT = 3'b100,
        ALU_XOR = 3'b101,
        ALU_NEG = 3'b110,
        ALU_SHL = 3'b111
    } alu_op_e;

    // Codes with bit 3 clear; 0011..0111 behave as READ
    localparam logic [CMD_W-1:0] CMD_LOAD  = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_CLEAR = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_READ  = 4'b0010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  op;
        logic [DATA_W-1:0] data;
    } cmd_t;

    function automatic logic is_alu_cmd(input logic [CMD_W-1:0] op);
        return op[CMD_W-1];
    endfunction

endpackage

// File: rtl/alu_acc_ctrl_if.sv
// Command, ALU and response signals of the accumulator controller.
// The controller uses the slave view; its environment uses the master view.
interface alu_acc_ctrl_if
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CMD_W-1:0]     cmd_op;
    logic [DATA_W-1:0]    cmd_data;
    logic [OPT_W-1:0]     alu_option;
    logic [DATA_W-1:0]    alu_in1;
    logic [DATA_W-1:0]    alu_in2;
    logic [DATA_W-1:0]    alu_out;
    logic                 alu_cout;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DATA_W-1:0]    resp_acc;
    logic                 resp_carry;
    logic                 resp_zero;
    logic [CNT_W-1:0]     op_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, alu_out, alu_cout, resp_ready,
        output cmd_ready, alu_option, alu_in1, alu_in2,
               resp_valid, resp_acc, resp_carry, resp_zero, op_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, alu_out, alu_cout, resp_ready,
        input  cmd_ready, alu_option, alu_in1, alu_in2,
               resp_valid, resp_acc, resp_carry, resp_zero, op_count
    );

endinterface

// File: rtl/alu_acc_ctrl.sv
// Single-issue accumulator sequencer in front of a combinational 4-bit ALU:
// accept command, let the ALU settle for one cycle, write back, respond.
module alu_acc_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_acc_ctrl_if.slave bus
);

    state_e              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, command latch and writeback
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d.op   = bus.cmd_op;
                    cmd_d.data = bus.cmd_data;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_RESP;
                if (is_alu_cmd(cmd_q.op)) begin
                    acc_d   = bus.alu_out;
                    carry_d = bus.alu_cout;
                end else begin
                    case (cmd_q.op)
                        CMD_LOAD: begin
                            acc_d   = cmd_q.data;
                            carry_d = 1'b0;
                        end
                        CMD_CLEAR: begin
                            acc_d   = '0;
                            carry_d = 1'b0;
                        end
                        default: begin
                            acc_d   = acc_q;
                            carry_d = carry_q;
                        end
                    endcase
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is gated by reset so no command is taken while reset is held
    assign bus.cmd_ready  = rst_n && (state_q == ST_IDLE);

    assign bus.alu_option = cmd_q.op[OPT_W-1:0];
    assign bus.alu_in1    = acc_q;
    assign bus.alu_in2    = cmd_q.data;

    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_acc   = acc_q;
    assign bus.resp_carry = carry_q;
    assign bus.resp_zero  = (acc_q == '0);
    assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Scoreboard bench for alu_acc_ctrl: a behavioural ALU sits beside the DUT,
// a reference model pushes expected responses at command acceptance.
module tb_alu_acc_ctrl;
    import alu_pkg::*;

    localparam logic [3:0] C_ADD = {1'b1, ALU_ADD};
    localparam logic [3:0] C_SUB = {1'b1, ALU_SUB};
    localparam logic [3:0] C_AND = {1'b1, ALU_AND};
    localparam logic [3:0] C_OR  = {1'b1, ALU_OR};
    localparam logic [3:0] C_NOT = {1'b1, ALU_NOT};
    localparam logic [3:0] C_XOR = {1'b1, ALU_XOR};
    localparam logic [3:0] C_NEG = {1'b1, ALU_NEG};
    localparam logic [3:0] C_SHL = {1'b1, ALU_SHL};
    localparam logic [3:0] C_RSV = 4'b0101;

    typedef struct packed {
        logic [3:0] acc;
        logic       carry;
        logic       zero;
        logic [7:0] cnt;
        logic [2:0] opt;
        logic [3:0] in2;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    logic [3:0] m_acc;
    logic       m_carry;
    logic [7:0] m_cnt;

    alu_acc_ctrl_if #(.CNT_W(8)) bus  ();
    alu_acc_ctrl_if #(.CNT_W(2)) bus2 ();

    alu_acc_ctrl #(.CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    alu_acc_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    // Behavioural stand-in for the external 4-bit ALU
    function automatic logic [4:0] alu_f(input logic [2:0] o, input logic [3:0] a,
                                         input logic [3:0] b);
        case (o)
            ALU_ADD: return {1'b0, a} + {1'b0, b};
            ALU_SUB: return {1'b0, a} - {1'b0, b};
            ALU_AND: return {1'b0, a & b};
            ALU_OR:  return {1'b0, a | b};
            ALU_NOT: return {1'b0, ~a};
            ALU_XOR: return {1'b0, a ^ b};
            ALU_NEG: return {1'b0, 4'(~a + 4'd1)};
            default: return {a[3], a[2:0], 1'b0};
        endcase
    endfunction

    assign {bus.alu_cout, bus.alu_out}   = alu_f(bus.alu_option, bus.alu_in1, bus.alu_in2);
    assign {bus2.alu_cout, bus2.alu_out} = alu_f(bus2.alu_option, bus2.alu_in1, bus2.alu_in2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_exec(input logic [3:0] op, input logic [3:0] d);
        exp_t       e;
        logic [4:0] r;
        if (op[3]) begin
            r       = alu_f(op[2:0], m_acc, d);
            m_acc   = r[3:0];
            m_carry = r[4];
        end else if (op == CMD_LOAD) begin
            m_acc   = d;
            m_carry = 1'b0;
        end else if (op == CMD_CLEAR) begin
            m_acc   = 4'd0;
            m_carry = 1'b0;
        end
        m_cnt   = m_cnt + 8'd1;
        e.acc   = m_acc;
        e.carry = m_carry;
        e.zero  = (m_acc == 4'd0);
        e.cnt   = m_cnt;
        e.opt   = op[2:0];
        e.in2   = d;
        sb_q.push_back(e);
    endtask

    // Called at a negedge with cmd_valid high; returns #1 after the accepting edge
    task automatic wait_accept(output bit ok);
        int n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = bus.cmd_ready;
        if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pop and compare one response, then complete its handshake
    task automatic get_resp();
        exp_t e;
        int   n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.resp_valid) begin
            check_eq("resp_timeout", 32'd0, 32'd1);
            return;
        end
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check_eq("resp_acc",   32'(bus.resp_acc),   32'(e.acc));
        check_eq("resp_carry", 32'(bus.resp_carry), 32'(e.carry));
        check_eq("resp_zero",  32'(bus.resp_zero),  32'(e.zero));
        check_eq("op_count",   32'(bus.op_count),   32'(e.cnt));
        check_eq("alu_option", 32'(bus.alu_option), 32'(e.opt));
        check_eq("alu_in2",    32'(bus.alu_in2),    32'(e.in2));
        check_eq("alu_in1",    32'(bus.alu_in1),    32'(e.acc));
        check_eq("resp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check_eq("idle_after_resp", 32'(bus.cmd_ready), 32'd1);
        check_eq("valid_after_resp", 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [3:0] d,
                           input logic [3:0] ea, input logic ec);
        bit ok;
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        wait_accept(ok);
        bus.cmd_valid = 1'b0;
        if (!ok) return;
        model_exec(op, d);
        check_eq("exec_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("exec_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("lat_valid", 32'(bus.resp_valid), 32'd1);
        check_eq("dir_acc",   32'(bus.resp_acc),   32'(ea));
        check_eq("dir_carry", 32'(bus.resp_carry), 32'(ec));
        get_resp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        n_checks = 0;
        n_fail   = 0;
        m_acc = 4'd0; m_carry = 1'b0; m_cnt = 8'd0;
        rst_n = 1'b0;
        bus.cmd_valid  = 1'b0; bus.cmd_op  = 4'd0; bus.cmd_data  = 4'd0; bus.resp_ready  = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_op = 4'd0; bus2.cmd_data = 4'd0; bus2.resp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready),  32'd0);
        check_eq("rst_valid",     32'(bus.resp_valid), 32'd0);
        check_eq("rst_acc",       32'(bus.alu_in1),    32'd0);
        check_eq("rst_carry",     32'(bus.resp_carry), 32'd0);
        check_eq("rst_count",     32'(bus.op_count),   32'd0);
        check_eq("rst_option",    32'(bus.alu_option), 32'd0);
        check_eq("rst_in2",       32'(bus.alu_in2),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Load / add, read keeps carry
        run_cmd(CMD_LOAD, 4'h9, 4'h9, 1'b0);
        run_cmd(C_ADD,    4'h8, 4'h1, 1'b1);
        run_cmd(CMD_READ, 4'h3, 4'h1, 1'b1);
        // Subtract with borrow, then to zero
        run_cmd(CMD_LOAD, 4'h1, 4'h1, 1'b0);
        run_cmd(C_SUB,    4'h3, 4'hE, 1'b1);
        run_cmd(C_SUB,    4'hE, 4'h0, 1'b0);
        // Shift, negate, read
        run_cmd(CMD_LOAD, 4'h9, 4'h9, 1'b0);
        run_cmd(C_SHL,    4'h0, 4'h2, 1'b1);
        run_cmd(C_NEG,    4'h0, 4'hE, 1'b0);
        run_cmd(CMD_READ, 4'h0, 4'hE, 1'b0);
        // Logic ops, reserved code, clear
        run_cmd(CMD_LOAD, 4'hC, 4'hC, 1'b0);
        run_cmd(C_AND,    4'hA, 4'h8, 1'b0);
        run_cmd(C_OR,     4'h3, 4'hB, 1'b0);
        run_cmd(C_XOR,    4'hF, 4'h4, 1'b0);
        run_cmd(C_NOT,    4'h0, 4'hB, 1'b0);
        run_cmd(C_RSV,    4'h6, 4'hB, 1'b0);
        run_cmd(CMD_CLEAR, 4'h5, 4'h0, 1'b0);

        // Backpressure with a second command held on the input
        run_cmd(CMD_LOAD, 4'h7, 4'h7, 1'b0);
        @(negedge clk);
        bus.cmd_op = C_ADD; bus.cmd_data = 4'h5; bus.cmd_valid = 1'b1;
        wait_accept(ok);
        if (ok) begin
            model_exec(C_ADD, 4'h5);
            bus.cmd_data = 4'h1;
            @(posedge clk);
            #1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check_eq("bp_valid", 32'(bus.resp_valid), 32'd1);
                check_eq("bp_acc",   32'(bus.resp_acc),   32'hC);
                check_eq("bp_carry", 32'(bus.resp_carry), 32'd0);
                check_eq("bp_ready", 32'(bus.cmd_ready),  32'd0);
            end
            get_resp();
            @(posedge clk);
            #1;
            check_eq("bp_accept", 32'(bus.cmd_ready), 32'd0);
            bus.cmd_valid = 1'b0;
            model_exec(C_ADD, 4'h1);
            @(posedge clk);
            #1;
            check_eq("bp2_valid", 32'(bus.resp_valid), 32'd1);
            check_eq("bp2_acc",   32'(bus.resp_acc),   32'hD);
            get_resp();
        end
        bus.cmd_valid = 1'b0;

        // Reset during EXEC aborts the command
        run_cmd(CMD_LOAD, 4'h7, 4'h7, 1'b0);
        @(negedge clk);
        bus.cmd_op = C_ADD; bus.cmd_data = 4'h3; bus.cmd_valid = 1'b1;
        wait_accept(ok);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_forced_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("abort_acc",   32'(bus.alu_in1),    32'd0);
        check_eq("abort_carry", 32'(bus.resp_carry), 32'd0);
        check_eq("abort_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("abort_count", 32'(bus.op_count),   32'd0);
        check_eq("abort_zero",  32'(bus.resp_zero),  32'd1);
        m_acc = 4'd0; m_carry = 1'b0; m_cnt = 8'd0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_rel_ready", 32'(bus.cmd_ready), 32'd1);
        run_cmd(C_ADD, 4'h2, 4'h2, 1'b0);

        // Counter wrap on the narrow instance
        for (int i = 0; i < 7; i++) begin
            int n = 0;
            @(negedge clk);
            bus2.cmd_op    = (i < 5) ? CMD_READ : ((i == 5) ? CMD_LOAD : CMD_CLEAR);
            bus2.cmd_data  = 4'h5;
            bus2.cmd_valid = 1'b1;
            while (!bus2.cmd_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!bus2.cmd_ready) begin
                check_eq("wrap_accept_timeout", 32'd0, 32'd1);
                bus2.cmd_valid = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            bus2.cmd_valid = 1'b0;
            @(posedge clk);
            #1;
            check_eq("wrap_valid", 32'(bus2.resp_valid), 32'd1);
            check_eq("wrap_count", 32'(bus2.op_count),   32'((i + 1) % 4));
            if (i == 5) check_eq("wrap_load_acc", 32'(bus2.resp_acc), 32'h5);
            if (i == 6) check_eq("wrap_clear_zero", 32'(bus2.resp_zero), 32'd1);
            bus2.resp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus2.resp_ready = 1'b0;
        end

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
